// File: rtl/spi_device_lite.sv
// SPI mode-0 target with oversampled pad inputs, RX/TX byte FIFOs toward the SoC,
// overflow/underflow pulses and a level RX interrupt.
module spi_device_lite #(
   parameter int unsigned FifoDepth  = 8,
   parameter int unsigned SyncStages = 2,
   parameter bit          LsbFirst   = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       spi_sclk_i,
   input  logic       spi_cs_ni,
   input  logic       spi_sd_i,
   output logic       spi_sd_o,
   output logic       spi_sd_oe_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       rx_overflow_o,
   output logic       tx_underflow_o,
   output logic       intr_rx_o,
   output logic       busy_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);
   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StActive = 1'b1;

   // pad synchronizers plus edge-detect history
   logic [SyncStages-1:0] sclk_sync_q, cs_sync_q, sd_sync_q;
   logic                  sclk_hist_q, cs_hist_q;
   logic                  sclk_s, cs_s, sd_s;
   logic                  sck_rise, sck_fall, cs_fall, cs_rise;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         sd_sync_q   <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], spi_sclk_i};
         cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_ni};
         sd_sync_q   <= {sd_sync_q[SyncStages-2:0], spi_sd_i};
         sclk_hist_q <= sclk_s;
         cs_hist_q   <= cs_s;
      end
   end

   assign sclk_s   = sclk_sync_q[SyncStages-1];
   assign cs_s     = cs_sync_q[SyncStages-1];
   assign sd_s     = sd_sync_q[SyncStages-1];
   assign sck_rise = sclk_s & ~sclk_hist_q;
   assign sck_fall = ~sclk_s & sclk_hist_q;
   assign cs_fall  = ~cs_s & cs_hist_q;
   assign cs_rise  = cs_s & ~cs_hist_q;

   logic [0:0]      state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            load_pend_q, load_pend_d;
   logic            rx_push_q, rx_push_d;
   logic            udf_q, oe_q;
   logic            load;

   logic [7:0]      rx_mem_q [FifoDepth];
   logic [7:0]      tx_mem_q [FifoDepth];
   logic [PtrW-1:0] rx_wr_ptr_q, rx_rd_ptr_q, tx_wr_ptr_q, tx_rd_ptr_q;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic            rx_pop, rx_full, rx_wr, tx_push, tx_pop, tx_empty;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      load_pend_d = load_pend_q;
      rx_push_d   = 1'b0;
      load        = 1'b0;
      if (state_q == StIdle) begin
         if (cs_fall) begin
            state_d     = StActive;
            load        = 1'b1;
            bit_cnt_d   = '0;
            load_pend_d = 1'b0;
         end
      end else if (cs_rise) begin
         // deselect beats any same-cycle SCLK edge and drops partial bytes
         state_d     = StIdle;
         bit_cnt_d   = '0;
         load_pend_d = 1'b0;
      end else begin
         if (sck_rise) begin
            rx_shift_d = LsbFirst ? {sd_s, rx_shift_q[7:1]} : {rx_shift_q[6:0], sd_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               rx_push_d   = 1'b1;
               load_pend_d = 1'b1;
            end
         end
         if (sck_fall) begin
            if (load_pend_q) begin
               load        = 1'b1;
               load_pend_d = 1'b0;
            end else begin
               tx_shift_d = LsbFirst ? {1'b1, tx_shift_q[7:1]} : {tx_shift_q[6:0], 1'b1};
            end
         end
      end
      if (load) tx_shift_d = tx_empty ? 8'hFF : tx_mem_q[tx_rd_ptr_q];
   end

   // FIFO bookkeeping; a load only sees TX entries present before this cycle
   assign rx_valid_o    = (rx_cnt_q != '0);
   assign rx_pop        = rx_valid_o & rx_ready_i;
   assign rx_full       = (rx_cnt_q == DepthC);
   assign rx_wr         = rx_push_q & (~rx_full | rx_pop);
   assign rx_overflow_o = rx_push_q & rx_full & ~rx_pop;
   assign rx_data_o     = rx_mem_q[rx_rd_ptr_q];

   assign tx_empty   = (tx_cnt_q == '0);
   assign tx_ready_o = (tx_cnt_q != DepthC);
   assign tx_push    = tx_valid_i & tx_ready_o;
   assign tx_pop     = load & ~tx_empty;

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (rx_wr && !rx_pop) rx_cnt_d = rx_cnt_q + CntW'(1);
      else if (!rx_wr && rx_pop) rx_cnt_d = rx_cnt_q - CntW'(1);
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CntW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         load_pend_q <= 1'b0;
         rx_push_q   <= 1'b0;
         udf_q       <= 1'b0;
         oe_q        <= 1'b0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         tx_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         load_pend_q <= load_pend_d;
         rx_push_q   <= rx_push_d;
         udf_q       <= load & tx_empty;
         oe_q        <= ~cs_s;
         rx_cnt_q    <= rx_cnt_d;
         tx_cnt_q    <= tx_cnt_d;
         if (rx_wr)   rx_wr_ptr_q <= rx_wr_ptr_q + PtrW'(1);
         if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PtrW'(1);
         if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PtrW'(1);
         if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rx_wr)   rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_data_i;
   end

   assign spi_sd_o       = LsbFirst ? tx_shift_q[0] : tx_shift_q[7];
   assign spi_sd_oe_o    = oe_q;
   assign tx_underflow_o = udf_q;
   assign intr_rx_o      = rx_valid_o;
   assign busy_o         = (state_q == StActive);

endmodule

// File: tb/tb_spi_device_lite.sv
// Scoreboard bench for spi_device_lite: a pad-level SPI host drives frames, expected
// RX bytes and MISO bytes are queued and checked by independent monitors.
module tb_spi_device_lite;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_sd = 1'b0;
   logic       spi_sd_o, spi_sd_oe_o;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0, tx_ready;
   logic       rx_ovf, tx_udf, intr_rx, busy;

   int errors = 0;
   int checks = 0;
   int udf_cnt = 0;
   int ovf_cnt = 0;
   logic [7:0] rx_exp[$];
   logic [7:0] miso_exp[$];

   always #5 clk = ~clk;

   spi_device_lite dut (
      .clk_i(clk), .rst_ni(rst_n),
      .spi_sclk_i(spi_sclk), .spi_cs_ni(spi_cs_n), .spi_sd_i(spi_sd),
      .spi_sd_o(spi_sd_o), .spi_sd_oe_o(spi_sd_oe_o),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .rx_overflow_o(rx_ovf), .tx_underflow_o(tx_udf),
      .intr_rx_o(intr_rx), .busy_o(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_push(input logic [7:0] b);
      tx_data = b; tx_valid = 1'b1;
      clk_wait(1);
      tx_valid = 1'b0;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      clk_wait(8);
      chk("busy_sel", busy, 1);
      chk("oe_sel", spi_sd_oe_o, 1);
   endtask

   // SCLK = clk/8; on the last byte CS rises together with the final SCLK fall
   task automatic spi_byte(input logic [7:0] b, input bit last);
      for (int i = 7; i >= 0; i--) begin
         spi_sd = b[i];
         clk_wait(4);
         spi_sclk = 1'b1;
         clk_wait(4);
         spi_sclk = 1'b0;
         if (i == 0 && last) spi_cs_n = 1'b1;
      end
      if (last) begin
         clk_wait(8);
         chk("busy_idle", busy, 0);
         chk("oe_idle", spi_sd_oe_o, 0);
      end
   endtask

   task automatic spi_partial(input logic [7:0] b, input int n, input bit end_cs);
      for (int i = 0; i < n; i++) begin
         spi_sd = b[7-i];
         clk_wait(4);
         spi_sclk = 1'b1;
         clk_wait(4);
         spi_sclk = 1'b0;
      end
      clk_wait(4);
      if (end_cs) begin
         spi_cs_n = 1'b1;
         clk_wait(8);
      end
   endtask

   // RX stream monitor, pulse counters and interrupt mirror check
   initial begin
      forever begin
         @(negedge clk);
         if (tx_udf) udf_cnt++;
         if (rx_ovf) ovf_cnt++;
         chk("intr_eq_valid", intr_rx, rx_valid);
         if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
               chk("rx_data", rx_data, rx_exp.pop_front());
            end
         end
      end
   end

   // MISO monitor: samples at the host's SCLK rise, restarts on deselect
   initial begin
      logic [7:0] sh;
      int n;
      n = 0; sh = '0;
      forever begin
         @(posedge spi_sclk or posedge spi_cs_n);
         if (spi_cs_n) n = 0;
         else begin
            sh = {sh[6:0], spi_sd_o};
            n++;
            if (n == 8) begin
               n = 0;
               if (miso_exp.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL miso_unexpected: got %0h expected none", sh);
               end else chk("miso_byte", sh, miso_exp.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int u0, o0;
      // reset values
      clk_wait(3);
      chk("rst_sd", spi_sd_o, 0);
      chk("rst_oe", spi_sd_oe_o, 0);
      chk("rst_rxv", rx_valid, 0);
      chk("rst_txr", tx_ready, 1);
      chk("rst_ovf", rx_ovf, 0);
      chk("rst_udf", tx_udf, 0);
      chk("rst_intr", intr_rx, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      clk_wait(4);

      // basic byte: TX 3C, host sends A5
      u0 = udf_cnt;
      tx_push(8'h3C);
      miso_exp.push_back(8'h3C); rx_exp.push_back(8'hA5);
      cs_low();
      spi_byte(8'hA5, 1'b1);
      chk("t1_udf", udf_cnt - u0, 0);

      // TX empty: MISO FF, one underflow
      u0 = udf_cnt;
      miso_exp.push_back(8'hFF); rx_exp.push_back(8'hC3);
      cs_low();
      spi_byte(8'hC3, 1'b1);
      chk("t2_udf", udf_cnt - u0, 1);

      // RX overflow: 9 bytes with no pops
      u0 = udf_cnt; o0 = ovf_cnt;
      rx_ready = 1'b0;
      cs_low();
      for (int i = 1; i <= 9; i++) begin
         logic [7:0] b;
         b = 8'(i);
         miso_exp.push_back(8'hFF);
         if (i <= 8) rx_exp.push_back(b);
         spi_byte(b, i == 9);
         clk_wait(2);
         if (i == 8) chk("t3_ovf_pre", ovf_cnt - o0, 0);
      end
      chk("t3_ovf", ovf_cnt - o0, 1);
      chk("t3_udf", udf_cnt - u0, 9);
      chk("t3_full_valid", rx_valid, 1);
      rx_ready = 1'b1;
      clk_wait(12);
      chk("t3_drained", rx_exp.size(), 0);
      chk("t3_empty", rx_valid, 0);

      // mid-frame deselect, then a full byte
      u0 = udf_cnt; o0 = ovf_cnt;
      tx_push(8'h77); tx_push(8'h88);
      cs_low();
      spi_partial(8'hF0, 5, 1'b1);
      chk("t4_no_push", rx_valid, 0);
      miso_exp.push_back(8'h88); rx_exp.push_back(8'h5A);
      cs_low();
      spi_byte(8'h5A, 1'b1);
      clk_wait(4);
      chk("t4_single", rx_exp.size(), 0);
      chk("t4_udf", udf_cnt - u0, 0);
      chk("t4_ovf", ovf_cnt - o0, 0);

      // three bytes in one window
      u0 = udf_cnt; o0 = ovf_cnt;
      tx_push(8'hAA); tx_push(8'hBB); tx_push(8'hCC);
      miso_exp.push_back(8'hAA); miso_exp.push_back(8'hBB); miso_exp.push_back(8'hCC);
      rx_exp.push_back(8'h11); rx_exp.push_back(8'h22); rx_exp.push_back(8'h33);
      cs_low();
      spi_byte(8'h11, 1'b0);
      spi_byte(8'h22, 1'b0);
      spi_byte(8'h33, 1'b1);
      clk_wait(4);
      chk("t5_udf", udf_cnt - u0, 0);
      chk("t5_ovf", ovf_cnt - o0, 0);
      chk("t5_rx_done", rx_exp.size(), 0);

      // reset mid-frame with both FIFOs holding data
      tx_push(8'hA1); tx_push(8'hB2); tx_push(8'hC3);
      rx_ready = 1'b0;
      miso_exp.push_back(8'hA1); rx_exp.push_back(8'h42);
      cs_low();
      spi_byte(8'h42, 1'b0);
      spi_partial(8'hE0, 3, 1'b0);
      chk("t6_rx_held", rx_valid, 1);
      rx_exp.delete();
      rst_n = 1'b0;
      clk_wait(1);
      chk("t6_sd", spi_sd_o, 0);
      chk("t6_oe", spi_sd_oe_o, 0);
      chk("t6_rxv", rx_valid, 0);
      chk("t6_txr", tx_ready, 1);
      chk("t6_udf0", tx_udf, 0);
      chk("t6_ovf0", rx_ovf, 0);
      chk("t6_intr", intr_rx, 0);
      chk("t6_busy", busy, 0);
      u0 = udf_cnt;
      rst_n = 1'b1;
      // CS pad still low, so the resynced select reloads from the flushed TX FIFO
      clk_wait(8);
      chk("t6_tx_flushed", udf_cnt - u0, 1);
      chk("t6_rx_flushed", rx_valid, 0);
      spi_cs_n = 1'b1;
      clk_wait(8);
      rx_ready = 1'b1;
      clk_wait(4);

      chk("end_rx_q", rx_exp.size(), 0);
      chk("end_miso_q", miso_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
